// File: rtl/arm_run_ctrl.sv
// Run-control sequencer for the single-cycle ARMv4 core: core reset, clock enable,
// host command port and retired-instruction counter. Breakpoint logic: RUN_CTRL_BREAKPOINT_EN.
module arm_run_ctrl #(
   parameter int RESET_CYCLES = 4,
   parameter int STEP_W       = 8,
   parameter int PC_W         = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [2:0]      cmd_op,
   input  logic [31:0]     cmd_arg,
   input  logic [PC_W-1:0] cpu_pc,
   output logic            cpu_reset,
   output logic            cpu_ce,
   output logic [2:0]      state_o,
   output logic            halted,
   output logic            bp_hit,
   output logic [31:0]     instr_count
);

   localparam int TIMER_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(RESET_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1'b1);
   localparam logic [STEP_W-1:0]  STEP_ONE     = STEP_W'(1'b1);

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_RUN    = 3'd1;
   localparam logic [2:0] OP_HALT   = 3'd2;
   localparam logic [2:0] OP_STEP   = 3'd3;
   localparam logic [2:0] OP_RSTCPU = 3'd4;
   localparam logic [2:0] OP_SETBP  = 3'd5;
   localparam logic [2:0] OP_CLRBP  = 3'd6;

   typedef enum logic [2:0] {
      ST_CPU_RST = 3'd0,
      ST_HALT    = 3'd1,
      ST_RUN     = 3'd2,
      ST_STEP    = 3'd3,
      ST_BRK     = 3'd4
   } state_t;

   state_t             state_r, state_nx;
   logic [TIMER_W-1:0] timer_r, timer_nx;
   logic [STEP_W-1:0]  remaining_r, remaining_nx;
   logic [31:0]        instr_count_r, count_nx;
   logic               cpu_reset_r, cmd_ready_r, halted_r;
   logic               cmd_fire_s, cpu_ce_s, bp_match_s, at_bp_s;
   logic [STEP_W-1:0]  step_load_s;
   logic               unused_s;

   assign unused_s    = ^{cmd_arg, cpu_pc};
   assign cmd_fire_s  = cmd_valid && cmd_ready_r;
   assign step_load_s = (cmd_arg[STEP_W-1:0] == {STEP_W{1'b0}}) ? STEP_ONE : cmd_arg[STEP_W-1:0];

`ifdef RUN_CTRL_BREAKPOINT_EN
   logic [PC_W-1:0] bp_addr_r, bp_addr_nx;
   logic            bp_en_r, bp_en_nx;
   logic            bp_skip_r, bp_skip_nx;
   logic            bp_hit_r, bp_hit_nx;

   assign at_bp_s    = bp_en_r && (cpu_pc == bp_addr_r);
   assign bp_match_s = at_bp_s && !bp_skip_r;
   assign bp_hit     = bp_hit_r;

   // Breakpoint register, skip flag and sticky hit flag
   always_comb begin
      bp_addr_nx = bp_addr_r;
      bp_en_nx   = bp_en_r;
      bp_skip_nx = cpu_ce_s ? 1'b0 : bp_skip_r;
      bp_hit_nx  = bp_hit_r;
      if (cmd_fire_s) begin
         case (cmd_op)
            OP_SETBP: begin
               bp_addr_nx = cmd_arg[PC_W-1:0];
               bp_en_nx   = 1'b1;
            end
            OP_CLRBP: bp_en_nx = 1'b0;
            OP_RUN, OP_STEP: begin
               bp_hit_nx = 1'b0;
               // Resuming from the breakpointed PC lets that instruction retire once
               if ((state_r == ST_HALT) || (state_r == ST_BRK)) begin
                  bp_skip_nx = at_bp_s;
               end else begin
                  bp_skip_nx = bp_skip_r && !cpu_ce_s;
               end
            end
            OP_RSTCPU: begin
               bp_hit_nx  = 1'b0;
               bp_skip_nx = 1'b0;
            end
            default: bp_hit_nx = bp_hit_r;
         endcase
      end else begin
         bp_hit_nx = bp_hit_r;
      end
      if ((state_nx == ST_BRK) && (state_r != ST_BRK)) begin
         bp_hit_nx = 1'b1;
      end else begin
         bp_en_nx = bp_en_nx;
      end
   end

   // Breakpoint state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         bp_addr_r <= {PC_W{1'b0}};
         bp_en_r   <= 1'b0;
         bp_skip_r <= 1'b0;
         bp_hit_r  <= 1'b0;
      end else begin
         bp_addr_r <= bp_addr_nx;
         bp_en_r   <= bp_en_nx;
         bp_skip_r <= bp_skip_nx;
         bp_hit_r  <= bp_hit_nx;
      end
   end
`else
   assign at_bp_s    = 1'b0;
   assign bp_match_s = 1'b0;
   assign bp_hit     = 1'b0;
`endif

   assign cpu_ce_s = ((state_r == ST_RUN) || (state_r == ST_STEP)) && !bp_match_s;

   // Next-state, timer, step-count and instruction-counter logic
   always_comb begin
      state_nx     = state_r;
      timer_nx     = timer_r;
      remaining_nx = remaining_r;
      count_nx     = cpu_ce_s ? (instr_count_r + 32'd1) : instr_count_r;
      case (state_r)
         ST_CPU_RST: begin
            if (timer_r == {TIMER_W{1'b0}}) begin
               state_nx = ST_HALT;
               count_nx = 32'd0;
            end else begin
               timer_nx = timer_r - TIMER_ONE;
            end
         end
         ST_HALT, ST_BRK: begin
            if (cmd_fire_s) begin
               case (cmd_op)
                  OP_RUN:  state_nx = ST_RUN;
                  OP_STEP: begin
                     state_nx     = ST_STEP;
                     remaining_nx = step_load_s;
                  end
                  OP_RSTCPU: begin
                     state_nx = ST_CPU_RST;
                     timer_nx = TIMER_RELOAD;
                  end
                  default: state_nx = state_r;
               endcase
            end else begin
               state_nx = state_r;
            end
         end
         ST_RUN: begin
            // Core reset beats a breakpoint; a breakpoint beats a halt request
            if (cmd_fire_s && (cmd_op == OP_RSTCPU)) begin
               state_nx = ST_CPU_RST;
               timer_nx = TIMER_RELOAD;
            end else if (bp_match_s) begin
               state_nx = ST_BRK;
            end else if (cmd_fire_s && (cmd_op == OP_HALT)) begin
               state_nx = ST_HALT;
            end else begin
               state_nx = ST_RUN;
            end
         end
         ST_STEP: begin
            if (cpu_ce_s && (remaining_r != {STEP_W{1'b0}})) begin
               remaining_nx = remaining_r - STEP_ONE;
            end else begin
               remaining_nx = remaining_r;
            end
            if (cmd_fire_s && (cmd_op == OP_RSTCPU)) begin
               state_nx = ST_CPU_RST;
               timer_nx = TIMER_RELOAD;
            end else if (bp_match_s) begin
               state_nx = ST_BRK;
            end else if (cmd_fire_s && (cmd_op == OP_HALT)) begin
               state_nx = ST_HALT;
            end else if (cpu_ce_s && (remaining_r == STEP_ONE)) begin
               state_nx = ST_HALT;
            end else begin
               state_nx = ST_STEP;
            end
         end
         default: begin
            state_nx = ST_CPU_RST;
            timer_nx = TIMER_RELOAD;
         end
      endcase
   end

   // Sequencer state and registered status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_CPU_RST;
         timer_r       <= TIMER_RELOAD;
         remaining_r   <= {STEP_W{1'b0}};
         instr_count_r <= 32'd0;
         cpu_reset_r   <= 1'b1;
         cmd_ready_r   <= 1'b0;
         halted_r      <= 1'b0;
      end else begin
         state_r       <= state_nx;
         timer_r       <= timer_nx;
         remaining_r   <= remaining_nx;
         instr_count_r <= count_nx;
         cpu_reset_r   <= (state_nx == ST_CPU_RST);
         cmd_ready_r   <= (state_nx != ST_CPU_RST);
         halted_r      <= (state_nx == ST_HALT) || (state_nx == ST_BRK);
      end
   end

   assign cmd_ready   = cmd_ready_r;
   assign cpu_reset   = cpu_reset_r;
   assign cpu_ce      = cpu_ce_s;
   assign state_o     = state_r;
   assign halted      = halted_r;
   assign instr_count = instr_count_r;

endmodule

// File: tb/tb_arm_run_ctrl.sv
// Directed bench for arm_run_ctrl; a tiny core model advances cpu_pc by 4 on each enabled cycle.
module tb_arm_run_ctrl;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_RUN    = 3'd1;
   localparam logic [2:0] OP_HALT   = 3'd2;
   localparam logic [2:0] OP_STEP   = 3'd3;
   localparam logic [2:0] OP_RSTCPU = 3'd4;
   localparam logic [2:0] OP_SETBP  = 3'd5;
   localparam logic [2:0] OP_CLRBP  = 3'd6;
   localparam logic [2:0] OP_RSVD   = 3'd7;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = 3'd0;
   logic [31:0] cmd_arg = 32'd0;
   logic [31:0] cpu_pc = 32'd0;
   logic        cpu_reset, cpu_ce, halted, bp_hit;
   logic [2:0]  state_o;
   logic [31:0] instr_count;

   int checks = 0;
   int errors = 0;

   arm_run_ctrl #(.RESET_CYCLES(4), .STEP_W(8), .PC_W(32)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cpu_pc(cpu_pc), .cpu_reset(cpu_reset),
      .cpu_ce(cpu_ce), .state_o(state_o), .halted(halted), .bp_hit(bp_hit),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // core model: PC resets to 0 and advances one word per retired instruction
   always @(posedge clk) begin
      if (reset || cpu_reset) cpu_pc <= 32'd0;
      else if (cpu_ce)        cpu_pc <= cpu_pc + 32'd4;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic send_cmd(input logic [2:0] op, input logic [31:0] arg);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL cmd_ready op=%0d got %b want 1", op, cmd_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = 32'd0;
   endtask

   task automatic wait_halt();
      int n = 0;
      while (state_o !== 3'd1 && n < 30) begin
         @(negedge clk); n++;
      end
      checks++;
      if (state_o !== 3'd1) begin
         errors++; $display("FAIL wait_halt state got %0d want 1", state_o);
      end
   endtask

   task automatic test_reset();
      int n = 0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({state_o, cpu_reset, cpu_ce, cmd_ready, bp_hit, halted} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}
          || instr_count !== 32'd0) begin
         errors++; $display("FAIL reset_values st=%0d rst=%b ce=%b rdy=%b hit=%b cnt=%0d", state_o, cpu_reset, cpu_ce, cmd_ready, bp_hit, instr_count);
      end
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (cpu_reset === 1'b1) n++;
         if (cpu_reset === 1'b1 && cmd_ready !== 1'b0) begin
            checks++; errors++; $display("FAIL ready_in_cpu_rst got %b want 0", cmd_ready);
         end
         @(negedge clk);
      end
      checks++;
      if (n != 4) begin errors++; $display("FAIL reset_length got %0d want 4", n); end
      checks++;
      if ({state_o, cmd_ready, cpu_ce, halted} !== {3'd1, 1'b1, 1'b0, 1'b1} || instr_count !== 32'd0) begin
         errors++; $display("FAIL post_reset st=%0d rdy=%b ce=%b halted=%b cnt=%0d want 1 1 0 1 0", state_o, cmd_ready, cpu_ce, halted, instr_count);
      end
   endtask

   task automatic test_cmd_ignore();
      logic [2:0] ops [4] = '{OP_NOP, OP_RSVD, OP_HALT, OP_CLRBP};
      for (int i = 0; i < 4; i++) begin
         send_cmd(ops[i], 32'h0000_0005);
         @(negedge clk);
         checks++;
         if (state_o !== 3'd1 || cpu_ce !== 1'b0 || instr_count !== 32'd0) begin
            errors++; $display("FAIL ignore_op%0d st=%0d ce=%b cnt=%0d want 1 0 0", ops[i], state_o, cpu_ce, instr_count);
         end
      end
   endtask

   task automatic test_step();
      int n;
      n = 0;
      send_cmd(OP_STEP, 32'd3);
      for (int i = 0; i < 8; i++) begin @(negedge clk); if (cpu_ce === 1'b1) n++; end
      checks++;
      if (n != 3 || instr_count !== 32'd3 || state_o !== 3'd1) begin
         errors++; $display("FAIL step3 ce_cycles=%0d cnt=%0d st=%0d want 3 3 1", n, instr_count, state_o);
      end
      n = 0;
      send_cmd(OP_STEP, 32'd0);
      for (int i = 0; i < 8; i++) begin @(negedge clk); if (cpu_ce === 1'b1) n++; end
      checks++;
      if (n != 1 || instr_count !== 32'd4 || state_o !== 3'd1) begin
         errors++; $display("FAIL step0 ce_cycles=%0d cnt=%0d st=%0d want 1 4 1", n, instr_count, state_o);
      end
   endtask

   task automatic test_run_halt();
      send_cmd(OP_RUN, 32'd0);
      checks++;
      if (state_o !== 3'd2 || cpu_ce !== 1'b1 || halted !== 1'b0) begin
         errors++; $display("FAIL run_entry st=%0d ce=%b halted=%b want 2 1 0", state_o, cpu_ce, halted);
      end
      repeat (9) @(negedge clk);
      send_cmd(OP_HALT, 32'd0);
      checks++;
      if (state_o !== 3'd1 || cpu_ce !== 1'b0 || instr_count !== 32'd14 || halted !== 1'b1) begin
         errors++; $display("FAIL run_halt st=%0d ce=%b cnt=%0d halted=%b want 1 0 14 1", state_o, cpu_ce, instr_count, halted);
      end
   endtask

   task automatic test_wrap();
      int n = 0;
      @(negedge clk);
      force dut.instr_count_r = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.instr_count_r;
      send_cmd(OP_STEP, 32'd3);
      for (int i = 0; i < 8; i++) begin @(negedge clk); if (cpu_ce === 1'b1) n++; end
      checks++;
      if (instr_count !== 32'h0000_0001 || n != 3 || state_o !== 3'd1) begin
         errors++; $display("FAIL wrap cnt=%h ce_cycles=%0d st=%0d want 00000001 3 1", instr_count, n, state_o);
      end
   endtask

   task automatic test_reset_cpu();
      send_cmd(OP_RUN, 32'd0);
      repeat (3) @(negedge clk);
      send_cmd(OP_RSTCPU, 32'd0);
      checks++;
      if (state_o !== 3'd0 || cpu_reset !== 1'b1 || cmd_ready !== 1'b0 || cpu_ce !== 1'b0) begin
         errors++; $display("FAIL reset_cpu st=%0d rst=%b rdy=%b ce=%b want 0 1 0 0", state_o, cpu_reset, cmd_ready, cpu_ce);
      end
      wait_halt();
      checks++;
      if (instr_count !== 32'd0 || cpu_reset !== 1'b0) begin
         errors++; $display("FAIL reset_cpu_exit cnt=%0d rst=%b want 0 0", instr_count, cpu_reset);
      end
   endtask

   task automatic test_reset_mid_step();
      send_cmd(OP_STEP, 32'd200);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({state_o, cpu_reset, cpu_ce, cmd_ready, bp_hit, halted} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}
          || instr_count !== 32'd0) begin
         errors++; $display("FAIL mid_step_reset st=%0d rst=%b ce=%b rdy=%b hit=%b cnt=%0d", state_o, cpu_reset, cpu_ce, cmd_ready, bp_hit, instr_count);
      end
      @(negedge clk);
      reset = 1'b0;
      wait_halt();
      repeat (3) @(negedge clk);
      checks++;
      if (state_o !== 3'd1 || instr_count !== 32'd0) begin
         errors++; $display("FAIL step_discarded st=%0d cnt=%0d want 1 0", state_o, instr_count);
      end
   endtask

`ifdef RUN_CTRL_BREAKPOINT_EN
   task automatic test_breakpoint();
      int n = 0;
      send_cmd(OP_SETBP, 32'h0000_0020);
      send_cmd(OP_RUN, 32'd0);
      while (state_o !== 3'd4 && n < 30) begin @(negedge clk); n++; end
      checks++;
      if (state_o !== 3'd4 || bp_hit !== 1'b1 || cpu_ce !== 1'b0 || cpu_pc !== 32'h20
          || instr_count !== 32'd8 || halted !== 1'b1) begin
         errors++; $display("FAIL bp_stop st=%0d hit=%b ce=%b pc=%h cnt=%0d want 4 1 0 20 8", state_o, bp_hit, cpu_ce, cpu_pc, instr_count);
      end
      send_cmd(OP_STEP, 32'd1);
      checks++;
      if (bp_hit !== 1'b0 || cpu_ce !== 1'b1) begin
         errors++; $display("FAIL bp_resume hit=%b ce=%b want 0 1", bp_hit, cpu_ce);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (state_o !== 3'd1 || instr_count !== 32'd9 || cpu_pc !== 32'h24 || bp_hit !== 1'b0) begin
         errors++; $display("FAIL bp_step st=%0d cnt=%0d pc=%h hit=%b want 1 9 24 0", state_o, instr_count, cpu_pc, bp_hit);
      end
      // RESET_CPU issued in the very cycle the breakpoint matches
      send_cmd(OP_RSTCPU, 32'd0);
      wait_halt();
      send_cmd(OP_RUN, 32'd0);
      repeat (8) @(negedge clk);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_RSTCPU;
      checks++;
      if (cpu_pc !== 32'h20 || cpu_ce !== 1'b0) begin
         errors++; $display("FAIL bp_coincide_setup pc=%h ce=%b want 20 0", cpu_pc, cpu_ce);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = OP_NOP;
      checks++;
      if (state_o !== 3'd0 || cpu_reset !== 1'b1 || bp_hit !== 1'b0 || instr_count !== 32'd8) begin
         errors++; $display("FAIL rstcpu_beats_bp st=%0d rst=%b hit=%b cnt=%0d want 0 1 0 8", state_o, cpu_reset, bp_hit, instr_count);
      end
      wait_halt();
      send_cmd(OP_CLRBP, 32'd0);
   endtask
`else
   task automatic test_breakpoint();
      int seen = 0;
      send_cmd(OP_SETBP, 32'h0000_0020);
      send_cmd(OP_RUN, 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (state_o === 3'd4 || bp_hit === 1'b1) seen++;
      end
      checks++;
      if (seen != 0 || instr_count !== 32'd19 || cpu_pc !== 32'h4C) begin
         errors++; $display("FAIL bp_disabled brk_cycles=%0d cnt=%0d pc=%h want 0 19 4c", seen, instr_count, cpu_pc);
      end
      send_cmd(OP_HALT, 32'd0);
      checks++;
      if (state_o !== 3'd1 || bp_hit !== 1'b0) begin
         errors++; $display("FAIL bp_disabled_halt st=%0d hit=%b want 1 0", state_o, bp_hit);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_cmd_ignore();
      test_step();
      test_run_halt();
      test_wrap();
      test_reset_cpu();
      test_reset_mid_step();
      test_breakpoint();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
